stopwatch_datapath: RTL

//  Time-keeping datapath driven by the stopwatch control FSM's contaTempo/pausaDisplay/zeraTempo.

---
 rtl/stopwatch_datapath.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_datapath.sv
// Stopwatch time-keeping datapath.
// A prescaler divides clk down to tenths of a second and advances a BCD live
// count M:SS.d (0:00.0 .. 9:59.9). A separate display register follows the
// live count one cycle behind and can be frozen while counting continues.
// The displayed value is decoded onto four active-low 7-segment digits.
module stopwatch_datapath #(
  parameter int DECSEGUNDO = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        contaTempo,
  input  logic        pausaDisplay,
  input  logic        zeraTempo,
  output logic [15:0] digito,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        tick,
  output logic        wrap
);

  localparam int PW = (DECSEGUNDO > 2) ? $clog2(DECSEGUNDO) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DECSEGUNDO - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    sec_units_q, sec_units_d;
  logic [3:0]    tenths_q, tenths_d;
  logic [15:0]   disp_q, disp_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic          count_en;
  logic          advance;
  logic          at_max;
  logic [15:0]   live;

  // Clear beats counting; counting only happens when not clearing.
  assign count_en = contaTempo && !zeraTempo;
  assign advance  = count_en && (presc_q == PRESC_MAX);
  assign at_max   = (min_q == 4'd9) && (sec_tens_q == 4'd5) &&
                    (sec_units_q == 4'd9) && (tenths_q == 4'd9);
  assign live     = {min_q, sec_tens_q, sec_units_q, tenths_q};

  // Prescaler: free-running divider while counting, held otherwise.
  always_comb begin
    presc_d = presc_q;
    if (zeraTempo) begin
      presc_d = '0;
    end else if (count_en) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  // BCD live count: ripple carry tenths -> sec_units -> sec_tens (0-5) -> min.
  always_comb begin
    min_d       = min_q;
    sec_tens_d  = sec_tens_q;
    sec_units_d = sec_units_q;
    tenths_d    = tenths_q;
    if (zeraTempo) begin
      min_d       = 4'd0;
      sec_tens_d  = 4'd0;
      sec_units_d = 4'd0;
      tenths_d    = 4'd0;
    end else if (advance) begin
      if (tenths_q == 4'd9) begin
        tenths_d = 4'd0;
        if (sec_units_q == 4'd9) begin
          sec_units_d = 4'd0;
          if (sec_tens_q == 4'd5) begin
            sec_tens_d = 4'd0;
            min_d      = (min_q == 4'd9) ? 4'd0 : min_q + 4'd1;
          end else begin
            sec_tens_d = sec_tens_q + 4'd1;
          end
        end else begin
          sec_units_d = sec_units_q + 4'd1;
        end
      end else begin
        tenths_d = tenths_q + 4'd1;
      end
    end
  end

  // Pulses: tick on every advance, wrap only on the 9:59.9 -> 0:00.0 advance.
  always_comb begin
    tick_d = advance;
    wrap_d = advance && at_max;
  end

  // Display copy: clear, follow the live count, or freeze.
  always_comb begin
    disp_d = disp_q;
    if (zeraTempo) begin
      disp_d = 16'h0000;
    end else if (!pausaDisplay) begin
      disp_d = live;
    end
  end

  // State register for the whole datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      min_q       <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_units_q <= 4'd0;
      tenths_q    <= 4'd0;
      disp_q      <= 16'h0000;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      min_q       <= min_d;
      sec_tens_q  <= sec_tens_d;
      sec_units_q <= sec_units_d;
      tenths_q    <= tenths_d;
      disp_q      <= disp_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
    end
  end

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign digito = disp_q;
  assign tick   = tick_q;
  assign wrap   = wrap_q;
  assign hex3   = seg7(disp_q[15:12]);
  assign hex2   = seg7(disp_q[11:8]);
  assign hex1   = seg7(disp_q[7:4]);
  assign hex0   = seg7(disp_q[3:0]);

endmodule
